// File: rtl/raw_stream_pkg.sv
// Shared definitions for the RAW pixel stream stages.
//   RAW_PIX_W : bits per pixel
//   RAW_PPC   : pixels per packed input beat
//   RAW_CNT_W : width of line/frame statistics counters (also used by the matrix buffer)
// Pixel order inside a packed beat: pixel 0 (earliest) occupies the MSBs.
package raw_stream_pkg;

    localparam int RAW_PIX_W = 8;
    localparam int RAW_PPC   = 4;
    localparam int RAW_CNT_W = 12;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ser_state_e;

    // LSB position of pixel 'idx' within a packed word (pixel 0 at the top).
    function automatic int pix_lsb(input int idx, input int ppc, input int pix_w);
        return (ppc - 1 - idx) * pix_w;
    endfunction

endpackage

// File: rtl/raw_pixel_serializer_if.sv
// AXI-Stream style bundle used for both the packed RAW input and the
// single-pixel output.
//   tdata  : W-bit payload
//   tvalid : beat valid (master -> slave)
//   tready : beat accepted when tvalid & tready (slave -> master)
//   tuser  : start of frame
//   tlast  : end of line
interface raw_pixel_serializer_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tuser;
    logic         tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast, output tready);
endinterface

// File: rtl/raw_line_stats.sv
// Line width / frame height measurement on a pixel stream.
//   I_clk, I_rst   : clock, synchronous active-high reset
//   I_pix_hs       : pixel handshake (valid & ready) this cycle
//   I_tuser        : handshaken pixel is the first of a frame
//   I_tlast        : handshaken pixel is the last of a line
//   O_line_width   : pixel count of the last completed line
//   O_frame_lines  : line count of the last completed frame
//   O_frame_done   : one-cycle pulse when O_frame_lines updates
// All counters saturate instead of wrapping.
module raw_line_stats #(
    parameter int CNT_W = raw_stream_pkg::RAW_CNT_W
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_pix_hs,
    input  logic             I_tuser,
    input  logic             I_tlast,
    output logic [CNT_W-1:0] O_line_width,
    output logic [CNT_W-1:0] O_frame_lines,
    output logic             O_frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] line_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // A start-of-frame pixel closes the previous frame before its own
    // tlast (1-pixel line) is counted, so the line count restarts from 0.
    assign line_base = I_tuser ? '0 : line_cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pix_cnt       <= '0;
            line_cnt      <= '0;
            O_line_width  <= '0;
            O_frame_lines <= '0;
            O_frame_done  <= 1'b0;
        end else begin
            O_frame_done <= 1'b0;
            if (I_pix_hs) begin
                if (I_tuser && (line_cnt != '0)) begin
                    O_frame_lines <= line_cnt;
                    O_frame_done  <= 1'b1;
                end
                if (I_tlast) begin
                    O_line_width <= sat_inc(pix_cnt);
                    pix_cnt      <= '0;
                    line_cnt     <= sat_inc(line_base);
                end else begin
                    pix_cnt  <= sat_inc(pix_cnt);
                    line_cnt <= line_base;
                end
            end
        end
    end

endmodule

// File: rtl/raw_pixel_serializer.sv
// Serialises the PPC-pixel-per-beat RAW stream into one pixel per beat and
// realigns tuser/tlast to pixel granularity; also reports line width and
// frame height.
//   I_clk, I_rst   : clock, synchronous active-high reset
//   I_raw          : packed input stream (tuser on pixel 0, tlast on pixel PPC-1)
//   O_pix          : single-pixel output stream
//   O_line_width   : pixel count of the last completed line
//   O_frame_lines  : line count of the last completed frame
//   O_frame_done   : one-cycle pulse when O_frame_lines updates
module raw_pixel_serializer
    import raw_stream_pkg::*;
#(
    parameter int PIX_W = RAW_PIX_W,
    parameter int PPC   = RAW_PPC,
    parameter int CNT_W = RAW_CNT_W
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    raw_pixel_serializer_if.slave   I_raw,
    raw_pixel_serializer_if.master  O_pix,
    output logic [CNT_W-1:0]        O_line_width,
    output logic [CNT_W-1:0]        O_frame_lines,
    output logic                    O_frame_done
);

    localparam int                IDX_W    = (PPC > 1) ? $clog2(PPC) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PPC - 1);
    localparam int                WORD_W   = PIX_W * PPC;

    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              load;
    logic [WORD_W-1:0] hold_data_p0;
    logic              hold_tuser_p0;
    logic              hold_tlast_p0;
    logic              hold_valid;
    logic              last_pix;
    logic              out_hs;
    logic              in_rdy;
    logic              in_hs;
    logic [PIX_W-1:0]  pix_sel;

    assign hold_valid = (state_q == ST_FULL);
    assign last_pix   = (idx_q == LAST_IDX);
    assign out_hs     = hold_valid & O_pix.tready;
    // Accepting on the final handshake lets the next word reload with no bubble.
    assign in_rdy     = ~hold_valid | (last_pix & O_pix.tready);
    assign in_hs      = I_raw.tvalid & in_rdy;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d = ST_FULL;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_hs) begin
                    if (last_pix) begin
                        idx_d = '0;
                        if (in_hs) load    = 1'b1;
                        else       state_d = ST_EMPTY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Stage p0: holding register (payload only, qualified by hold_valid)
    always_ff @(posedge I_clk) begin
        if (load) begin
            hold_data_p0  <= I_raw.tdata;
            hold_tuser_p0 <= I_raw.tuser;
            hold_tlast_p0 <= I_raw.tlast;
        end
    end

    assign pix_sel = hold_data_p0[pix_lsb(int'(idx_q), PPC, PIX_W) +: PIX_W];

    // Gating with hold_valid keeps the outputs at 0 while empty, so the
    // unreset payload never leaks out.
    assign O_pix.tdata  = hold_valid ? pix_sel : '0;
    assign O_pix.tvalid = hold_valid;
    assign O_pix.tuser  = hold_valid & hold_tuser_p0 & (idx_q == '0);
    assign O_pix.tlast  = hold_valid & hold_tlast_p0 & last_pix;
    assign I_raw.tready = in_rdy;

    raw_line_stats #(
        .CNT_W (CNT_W)
    ) u_line_stats (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_pix_hs      (out_hs),
        .I_tuser       (O_pix.tuser),
        .I_tlast       (O_pix.tlast),
        .O_line_width  (O_line_width),
        .O_frame_lines (O_frame_lines),
        .O_frame_done  (O_frame_done)
    );

endmodule

// File: tb/tb_raw_pixel_serializer.sv
module tb_raw_pixel_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raw_pixel_serializer_if #(.W(32)) raw_if ();
    raw_pixel_serializer_if #(.W(8))  pix_if ();
    raw_pixel_serializer_if #(.W(32)) raw2_if ();
    raw_pixel_serializer_if #(.W(8))  pix2_if ();

    logic [11:0] line_width, frame_lines;
    logic        frame_done;
    logic [3:0]  sat_line_width, sat_frame_lines;
    logic        sat_frame_done;

    logic        st_hs, st_u, st_l;
    logic [11:0] st_lw, st_fl;
    logic        st_done;

    raw_pixel_serializer dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_raw         (raw_if),
        .O_pix         (pix_if),
        .O_line_width  (line_width),
        .O_frame_lines (frame_lines),
        .O_frame_done  (frame_done)
    );

    // Same stream into a 4-bit-counter instance to observe saturation.
    raw_pixel_serializer #(.CNT_W(4)) dut_sat (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_raw         (raw2_if),
        .O_pix         (pix2_if),
        .O_line_width  (sat_line_width),
        .O_frame_lines (sat_frame_lines),
        .O_frame_done  (sat_frame_done)
    );

    assign raw2_if.tdata  = raw_if.tdata;
    assign raw2_if.tvalid = raw_if.tvalid;
    assign raw2_if.tuser  = raw_if.tuser;
    assign raw2_if.tlast  = raw_if.tlast;
    assign pix2_if.tready = pix_if.tready;

    // Stats block on its own for the 1-pixel-line ordering case.
    raw_line_stats u_stats (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_pix_hs      (st_hs),
        .I_tuser       (st_u),
        .I_tlast       (st_l),
        .O_line_width  (st_lw),
        .O_frame_lines (st_fl),
        .O_frame_done  (st_done)
    );

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        int         lw;
        int         lws;
        int         fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   pos = 0;
    bit   bp_en = 0;
    bit   gap_armed = 0;
    int   gap_first = -1;
    int   gap_last = -1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         pend_lw = 0, pend_fr = 0, have_prev = 0;
    int         p_lw, p_lws, p_fl;
    logic [7:0] prev_d;
    logic       prev_u, prev_l;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            pos       = 0;
            pend_lw   = 0;
            pend_fr   = 0;
            have_prev = 0;
        end else begin
            if (pend_lw) begin
                chk("line_width", 64'(line_width), 64'(p_lw));
                chk("sat_line_width", 64'(sat_line_width), 64'(p_lws));
                pend_lw = 0;
            end
            if (pend_fr) begin
                chk("frame_done", 64'(frame_done), 64'(p_fl >= 0));
                if (p_fl >= 0) chk("frame_lines", 64'(frame_lines), 64'(p_fl));
                pend_fr = 0;
            end
            if (have_prev) begin
                chk("stall_hold", {pix_if.tvalid, pix_if.tuser, pix_if.tlast, pix_if.tdata},
                    {1'b1, prev_u, prev_l, prev_d});
                have_prev = 0;
            end
            chk("in_ready", 64'(raw_if.tready), 64'(!pix_if.tvalid || (pos == 3 && pix_if.tready)));
            if (pix_if.tvalid) begin
                if (pix_if.tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pixel: actual %02h, required no output", pix_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        n_pop++;
                        chk("pixel", {pix_if.tuser, pix_if.tlast, pix_if.tdata}, {e.u, e.l, e.d});
                        pend_fr = 1;
                        p_fl    = e.fl;
                        if (e.l) begin
                            pend_lw = 1;
                            p_lw    = e.lw;
                            p_lws   = e.lws;
                        end
                        if (gap_armed) begin
                            if (gap_first < 0) gap_first = cyc;
                            gap_last = cyc;
                        end
                    end
                    pos = (pos + 1) % 4;
                end else begin
                    have_prev = 1;
                    prev_d    = pix_if.tdata;
                    prev_u    = pix_if.tuser;
                    prev_l    = pix_if.tlast;
                end
            end
        end
    end

    // ---------------- back-pressure generator ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) pix_if.tready = ($urandom_range(0, 9) >= 3);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_beat(input logic [31:0] d, input logic u, input logic l,
                             input int lw, input int lws, input int fl);
        int   n;
        bit   acc;
        exp_t e;
        n   = 0;
        acc = 0;
        raw_if.tdata  = d;
        raw_if.tuser  = u;
        raw_if.tlast  = l;
        raw_if.tvalid = 1'b1;
        while (!acc && n < 400) begin
            @(negedge clk);
            if (raw_if.tready) begin
                acc = 1;
                for (int i = 0; i < 4; i++) begin
                    e.d   = d[31-8*i -: 8];
                    e.u   = u && (i == 0);
                    e.l   = l && (i == 3);
                    e.lw  = lw;
                    e.lws = lws;
                    e.fl  = (i == 0) ? fl : -1;
                    exp_q.push_back(e);
                end
            end else begin
                n++;
            end
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: beat %08h not accepted after %0d cycles, required acceptance", d, n);
        end
        @(posedge clk);
        #1;
        raw_if.tvalid = 1'b0;
        raw_if.tuser  = 1'b0;
        raw_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d pixels outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic stat_pix(input logic u, input logic l);
        st_hs = 1'b1;
        st_u  = u;
        st_l  = l;
        @(posedge clk);
        #1;
        st_hs = 1'b0;
        st_u  = 1'b0;
        st_l  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tvalid"}, 64'(pix_if.tvalid), 64'(0));
        chk({tag, "_tdata"}, 64'(pix_if.tdata), 64'(0));
        chk({tag, "_tuser_tlast"}, {pix_if.tuser, pix_if.tlast}, 64'(0));
        chk({tag, "_in_ready"}, 64'(raw_if.tready), 64'(1));
        chk({tag, "_line_width"}, 64'(line_width), 64'(0));
        chk({tag, "_frame_lines"}, 64'(frame_lines), 64'(0));
        chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    endtask

    initial begin
        logic [31:0] d;
        int          n0;
        rst           = 1'b1;
        raw_if.tvalid = 1'b0;
        raw_if.tdata  = '0;
        raw_if.tuser  = 1'b0;
        raw_if.tlast  = 1'b0;
        pix_if.tready = 1'b1;
        st_hs = 1'b0;
        st_u  = 1'b0;
        st_l  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // single beat, first pixel one cycle after acceptance
        send_beat(32'hA1B2C3D4, 1'b1, 1'b1, 4, 4, -1);
        @(negedge clk);
        chk("first_pixel_latency", {pix_if.tvalid, pix_if.tdata}, {1'b1, 8'hA1});
        drain();

        // gapless frame: 3 lines x 160 beats, then next frame start
        gap_first = -1;
        gap_armed = 1;
        for (int ln = 0; ln < 3; ln++) begin
            for (int b = 0; b < 160; b++) begin
                d = {ln[7:0], b[7:0], b[7:0] ^ 8'h5A, ~b[7:0]};
                send_beat(d, (ln == 0 && b == 0), (b == 159), 640, 15, (ln == 0 && b == 0) ? 1 : -1);
            end
        end
        send_beat(32'hF0E1D2C3, 1'b1, 1'b1, 4, 4, 3);
        drain();
        gap_armed = 0;
        chk("gapless_span", 64'(gap_last - gap_first), 64'(1923));

        // random back-pressure: 3-beat line then 5-beat line (saturates 4-bit width)
        bp_en = 1;
        send_beat(32'h01020304, 1'b1, 1'b0, 0, 0, 1);
        send_beat(32'h05060708, 1'b0, 1'b0, 0, 0, -1);
        send_beat(32'h090A0B0C, 1'b0, 1'b1, 12, 12, -1);
        for (int b = 0; b < 5; b++) begin
            d = {8'h80 | b[7:0], 8'h90 | b[7:0], 8'hA0 | b[7:0], 8'hB0 | b[7:0]};
            send_beat(d, 1'b0, (b == 4), 20, 15, -1);
        end
        drain();
        bp_en = 0;
        pix_if.tready = 1'b1;

        // 1-pixel line closing a 2-line frame
        stat_pix(1'b1, 1'b0);
        stat_pix(1'b0, 1'b1);
        stat_pix(1'b0, 1'b0);
        stat_pix(1'b0, 1'b1);
        stat_pix(1'b1, 1'b1);
        @(negedge clk);
        chk("one_pix_frame_done", 64'(st_done), 64'(1));
        chk("one_pix_frame_lines", 64'(st_fl), 64'(2));
        chk("one_pix_line_width", 64'(st_lw), 64'(1));
        @(negedge clk);
        chk("frame_done_pulse_width", 64'(st_done), 64'(0));
        stat_pix(1'b1, 1'b0);
        @(negedge clk);
        chk("restart_frame_done", 64'(st_done), 64'(1));
        chk("restart_frame_lines", 64'(st_fl), 64'(1));
        @(posedge clk);
        #1;

        // reset after 2 of 4 pixels
        n0 = n_pop;
        send_beat(32'h11223344, 1'b0, 1'b0, 0, 0, -1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_pixels_before", 64'(n_pop - n0), 64'(2));
        @(negedge clk);
        check_reset_state("rst_mid");
        @(posedge clk);
        #1;
        send_beat(32'h55667788, 1'b1, 1'b1, 4, 4, -1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/raw_pixel_serializer.md
# raw_pixel_serializer

Converts the 4-pixel-per-beat RAW8 AXI-Stream from the MIPI-to-RAW conversion stage into a 1-pixel-per-beat stream for the 3×3 matrix buffer and the downstream ISP stages. Frame/line sideband markers are realigned to pixel granularity. The block also measures line width and frame height for debug and format checking. It sits directly downstream of the RAW10→RAW8 packer, in the same clock domain.

## Interface
- `PIX_W`, default 8: bits per pixel.
- `PPC`, default 4: pixels per input beat. Input width is `PIX_W*PPC`.
- `CNT_W`, default 12: width of the line and pixel statistics counters.

Ports:
- `I_clk`, input, 1: pixel clock. Single clock domain.
- `I_rst`, input, 1: synchronous, active-high reset.
- `I_raw_tdata`, input, 32: four pixels. Pixel 0 (earliest) is in `[31:24]`, pixel 3 is in `[7:0]`.
- `I_raw_tvalid`, input, 1: input beat valid.
- `I_raw_tuser`, input, 1: start of frame; belongs to pixel 0 of the beat.
- `I_raw_tlast`, input, 1: end of line; belongs to pixel 3 of the beat.
- `I_raw_tready`, output, 1: input beat accepted when `tvalid & tready`.
- `O_pix_tdata`, output, 8: one pixel.
- `O_pix_tvalid`, output, 1: output pixel valid.
- `O_pix_tuser`, output, 1: start of frame, on the first pixel of the frame.
- `O_pix_tlast`, output, 1: end of line, on the last pixel of the line.
- `O_pix_tready`, input, 1: downstream ready.
- `O_line_width`, output, `CNT_W`: pixel count of the last completed line.
- `O_frame_lines`, output, `CNT_W`: line count of the last completed frame.
- `O_frame_done`, output, 1: single-cycle pulse when `O_frame_lines` updates.

## Operation
- **Holding register.** One 32-bit word plus its `tuser`/`tlast` bits, a `hold_valid` flag, and a 2-bit index `idx` (0..3).
- **Output mux.** `O_pix_tdata = hold[31-8*idx -: 8]`.
  - `O_pix_tvalid = hold_valid`.
  - `O_pix_tuser = hold_tuser & (idx==0)`.
  - `O_pix_tlast = hold_tlast & (idx==3)`.
- **States.** The block has two states.
  - EMPTY (`hold_valid=0`): `I_raw_tready=1`. An accepted beat loads the holding register, sets `idx=0` and moves to FULL.
  - FULL: each output handshake increments `idx`. When `idx==3` and a handshake occurs, one of two things happens:
    - If a new input beat is accepted in the same cycle, reload and set `idx=0`, staying in FULL (gapless).
    - Otherwise go to EMPTY.
- **Ready.** `I_raw_tready = ~hold_valid | (idx==3 & O_pix_tready)`. This is combinational from `O_pix_tready`.
- **Statistics.** All counters update on output handshakes only.
  - `pix_cnt` increments per pixel.
  - On a `tlast` pixel: `O_line_width <= pix_cnt+1`, `pix_cnt <= 0`, `line_cnt++`.
  - On a `tuser` pixel with `line_cnt != 0`: `O_frame_lines <= line_cnt`, `O_frame_done=1` for one cycle, and `line_cnt` restarts.
  - If a pixel carries both `tuser` and `tlast` (1-pixel line), the previous frame is closed first, then `line_cnt = 1`.
  - All counters saturate at `2^CNT_W-1` and do not wrap.
- **Framing errors are not corrected.** A missing `tlast` simply accumulates `pix_cnt`.

## Timing
- **Latency.** A beat accepted at edge N gives pixel 0 valid after edge N, so it is visible in cycle N+1. Pixels 1..3 follow at N+2..N+4 with no back-pressure.
- **Throughput.** One pixel per clock sustained. The input is accepted at most once every 4 cycles with no bubble between words.
- **Back-pressure.** When `O_pix_tready=0`, `O_pix_*` and `idx` hold stable. Valid never drops without a handshake.
- **Reset.** `I_rst` sampled high clears the following to 0: `hold_valid`, `idx`, all counters, `O_line_width`, `O_frame_lines` and `O_frame_done`. `O_pix_tvalid=0`, `O_pix_tuser=0`, `O_pix_tlast=0`, `O_pix_tdata=0`. `I_raw_tready=1` in the cycle after reset releases.
  - A reset mid-word discards the remaining pixels of the held word.

## Structure
- Shared package `raw_stream_pkg` holds:
  - `PIX_W` and `PPC` defaults.
  - The pixel-order convention (pixel 0 = MSBs).
  - The `CNT_W` default, reused by the matrix buffer.
- One sub-module, `raw_line_stats`, contains:
  - Inputs: pixel handshake, `tuser`, `tlast`.
  - Outputs: `O_line_width`, `O_frame_lines`, `O_frame_done`.
  - The same counter can be instantiated at other ISP stage boundaries.

## Test plan
- **Single beat.** Input `0xA1B2C3D4` with `tuser=1`, `tlast=1`, ready held high → output `A1`(tuser), `B2`, `C3`, `D4`(tlast) on 4 consecutive cycles, first one cycle after acceptance.
- **Gapless stream.** 160 beats per line, 3 lines, then `tuser` → no output bubbles, `O_line_width=640` after each line, `O_frame_lines=3` with a one-cycle `O_frame_done` at the next frame's first pixel.
- **Random back-pressure.** `O_pix_tready` random at 30% low → output sequence identical to the no-stall case, data stable while stalled, `I_raw_tready` high only when the register is empty or during the final handshake.
- **Reset mid-word.** Reset asserted after 2 of 4 pixels → next cycle `O_pix_tvalid=0` and statistics 0, and the remaining 2 pixels are never emitted.
- **Saturation.** With `CNT_W=4`, a 5-beat line (20 pixels) → `O_line_width=15`.
- **Counter order on 1-pixel line.** A pixel carrying both `tuser` and `tlast` after a 2-line frame → `O_frame_lines=2`, then `line_cnt` becomes 1.
